mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port synchronous instruction/data memory between the multicycle core's instruction-fetch port and its load/store port. Each access is a request/grant transaction with a registered response, and at most one access is outstanding. Arbitration is round-robin. The block sits between `core` and the memory macro, so fetch and data phases of the IF→WB sequence never collide on the memory.

## Interface
- `WORD_LEN`, 32: data width.
- `MEM_AW`, 14: word-address width.
- `MEM_LAT`, 1: memory read latency in cycles after the `mem_en` cycle; legal range 1–4.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset polarity and synchronicity are fixed.
- `i_req` in 1: fetch request, held until `i_gnt`.
- `i_addr` in `MEM_AW`: fetch word address.
- `i_gnt` out 1: one-cycle fetch grant.
- `i_rvalid` out 1: one-cycle fetch data valid.
- `i_rdata` out `WORD_LEN`: fetch data, held until the next fetch response.
- `d_req` in 1: data request, held until `d_gnt`.
- `d_we` in 1: 1 = store.
- `d_addr` in `MEM_AW`: data word address.
- `d_wdata` in `WORD_LEN`: store data.
- `d_wstrb` in 4: store byte strobes.
- `d_gnt` out 1: one-cycle data grant.
- `d_rvalid` out 1: one-cycle completion, for both loads and stores.
- `d_rdata` out `WORD_LEN`: load data, held until the next load response.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 4: byte write enables.
- `mem_addr` out `MEM_AW`: memory address.
- `mem_wdata` out `WORD_LEN`: memory write data.
- `mem_rdata` in `WORD_LEN`: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.
- `busy` out 1: high in ISSUE and WAIT.

## Operation
- States and transitions:
  - IDLE: arbitrate; on winner → ISSUE; otherwise stay in IDLE.
  - ISSUE: always → WAIT.
  - WAIT: lasts `MEM_LAT` cycles, then → RESP.
  - RESP: arbitrates exactly like IDLE; on winner → ISSUE, else → IDLE.
- Arbitration runs only in IDLE and RESP. Requests are ignored in ISSUE and WAIT.
- Tie-break: `last_gnt` register (0 = I, 1 = D). When both ports request, the port not granted last wins. `last_gnt` updates on every grant.
- Single requester: it wins regardless of `last_gnt`.
- The winner, owner bit, addr, we, wdata and wstrb are latched on the IDLE/RESP→ISSUE edge. Requester inputs are don't-care after `gnt`.
- ISSUE cycle:
  - `mem_en`=1.
  - Granted port's `gnt`=1.
  - `mem_we` = `d_wstrb` if the owner is D and `d_we`=1, else 4'b0000.
- WAIT counter: `lat_cnt` counts 1..`MEM_LAT`. On the last WAIT cycle, `mem_rdata` is captured into the owner's rdata register, except for stores.
- RESP cycle: the owner's `rvalid`=1. For a store, `d_rvalid` pulses and `d_rdata` is unchanged.
- Requester rule: deassert `req` by the cycle after `gnt`. A `req` still high in a RESP cycle is a new request.
- `mem_addr` and `mem_wdata` are registered and hold their last value outside ISSUE.
- Reset values, asynchronous:
  - State = IDLE, `last_gnt` = 0 (D wins the first tie).
  - All outputs 0, including `i_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` and `lat_cnt`.
- Reset mid-access: the transaction is dropped and no `rvalid` is issued. A store already strobed in ISSUE may have completed in memory.
- `i_gnt` and `d_gnt` are never high together. `i_rvalid` and `d_rvalid` are never high together.

## Timing
- Request first seen in IDLE at cycle T:
  - `gnt` and `mem_en` in T+1.
  - WAIT covers T+2..T+1+`MEM_LAT`.
  - `rvalid` in T+2+`MEM_LAT`.
- Back-to-back throughput: one access per `MEM_LAT`+2 cycles (RESP overlaps the next arbitration).
- All outputs are registered. There are no combinational paths from `*_req` to any output.
- `busy` rises in the ISSUE cycle and falls in the RESP cycle.

## Test plan
- Single fetch, `MEM_LAT`=1, with `i_addr`=0x010 and memory[0x010]=0x34333231:
  - `i_gnt` and `mem_en` at T+1.
  - `i_rvalid`=1 with `i_rdata`=0x34333231 at T+3.
  - `d_*` outputs stay 0.
- Simultaneous `i_req` and `d_req` out of reset:
  - D granted first, then I granted in D's RESP cycle.
  - A third tie goes to D.
  - Grants never overlap.
- Store with `d_addr`=0x020, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'b0011:
  - `mem_we`=0011 for exactly one cycle.
  - `d_rvalid` pulses.
  - `d_rdata` is unchanged.
  - A subsequent load of 0x020 returns the low half updated.
- `MEM_LAT`=4 with a continuous `i_req` held across RESP:
  - `mem_en` is asserted every 6 cycles.
  - `i_rdata` matches the addresses in order.
- Reset asserted during WAIT:
  - All outputs go to 0 immediately.
  - No `rvalid` follows.
  - The first post-reset tie goes to D.
- A `req` asserted only during ISSUE/WAIT and dropped before RESP is never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter for one single-port sync memory
module mem_arbiter #(
  parameter int WORD_LEN = 32,
  parameter int MEM_AW   = 14,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [MEM_AW-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [MEM_AW-1:0]   d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  input  logic [3:0]          d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_en,
  output logic [3:0]          mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  state_t     state;
  logic       last_gnt;
  logic       owner_d;
  logic       is_store;
  logic [2:0] lat_cnt;

  logic win;
  logic pick_d;

  // D wins when alone, or on a tie when I was granted last (last_gnt = 0).
  assign win    = i_req | d_req;
  assign pick_d = d_req & (~i_req | ~last_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_gnt  <= 1'b0;
      owner_d   <= 1'b0;
      is_store  <= 1'b0;
      lat_cnt   <= 3'd0;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 4'b0000;
      case (state)
        S_IDLE, S_RESP: begin
          if (win) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            owner_d  <= pick_d;
            last_gnt <= pick_d;
            is_store <= pick_d & d_we;
            i_gnt    <= ~pick_d;
            d_gnt    <= pick_d;
            mem_en   <= 1'b1;
            mem_we   <= (pick_d & d_we) ? d_wstrb : 4'b0000;
            mem_addr <= pick_d ? d_addr : i_addr;
            if (pick_d) mem_wdata <= d_wdata;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          lat_cnt <= 3'd1;
        end
        S_WAIT: begin
          // mem_rdata is valid on the last WAIT cycle; stores leave d_rdata alone.
          if (lat_cnt == LAT_LAST) begin
            state <= S_RESP;
            busy  <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              if (!is_store) d_rdata <= mem_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
